// File: rtl/matrix_uart_printer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : matrix_uart_printer                                            |
// | Desc     : Reads an m x n matrix row-major from storage and prints each   |
// |            element as signed decimal ASCII over an 8N1 UART transmitter.  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module matrix_uart_printer #(
   parameter int CLK_FREQ = 25_000_000,
   parameter int BAUD     = 115200,
   parameter int BAUD_DIV = CLK_FREQ / BAUD,
   parameter int MAX_DIM  = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [8:0]  i_base_addr,
   input  logic [31:0] i_m,
   input  logic [31:0] i_n,
   output logic [8:0]  o_rd_addr,
   input  logic [31:0] i_rd_data,
   output logic        o_tx,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error
);

   localparam int              c_BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(BAUD_DIV - 1);
   localparam logic [31:0]     c_MAX_DIM   = 32'(MAX_DIM);

   localparam logic [3:0] c_ST_IDLE  = 4'd0;
   localparam logic [3:0] c_ST_CHECK = 4'd1;
   localparam logic [3:0] c_ST_ADDR  = 4'd2;
   localparam logic [3:0] c_ST_READ  = 4'd3;
   localparam logic [3:0] c_ST_WAIT  = 4'd4;
   localparam logic [3:0] c_ST_CONV  = 4'd5;
   localparam logic [3:0] c_ST_SIGN  = 4'd6;
   localparam logic [3:0] c_ST_DIGIT = 4'd7;
   localparam logic [3:0] c_ST_SEP   = 4'd8;
   localparam logic [3:0] c_ST_LF    = 4'd9;
   localparam logic [3:0] c_ST_NEXT  = 4'd10;
   localparam logic [3:0] c_ST_DONE  = 4'd11;

   logic [3:0]       r_state, w_state_next;
   logic [8:0]       r_base, r_rd_addr;
   logic [31:0]      r_m, r_n;
   logic [2:0]       r_row, r_col;
   logic [4:0]       r_idx;
   logic             r_neg;
   logic [16:0]      r_mag;
   logic [4:0][3:0]  r_dig;
   logic [2:0]       r_pos, r_dpos;

   logic             r_tx, r_tx_active;
   logic [8:0]       r_tx_shift;
   logic [3:0]       r_bit_cnt;
   logic [c_BW-1:0]  r_baud_cnt;

   logic             w_dim_bad, w_last_col, w_last_row;
   logic             w_tx_ready, w_fmt_valid, w_load;
   logic [7:0]       w_fmt_byte;
   logic [16:0]      w_place, w_sub, w_elem_ext, w_elem_mag;
   logic [3:0]       w_digit;
   logic [2:0]       w_first;
   logic             w_unused;

   assign w_unused   = ^i_rd_data[31:16];
   assign w_dim_bad  = (r_m == 32'd0) || (r_m > c_MAX_DIM) || (r_n == 32'd0) || (r_n > c_MAX_DIM);
   assign w_last_col = ({29'd0, r_col} == r_n - 32'd1);
   assign w_last_row = ({29'd0, r_row} == r_m - 32'd1);
   assign w_elem_ext = {i_rd_data[15], i_rd_data[15:0]};
   assign w_elem_mag = i_rd_data[15] ? (~w_elem_ext + 17'd1) : w_elem_ext;
   assign w_tx_ready = !r_tx_active || ((r_bit_cnt == 4'd9) && (r_baud_cnt == c_BAUD_LAST));
   assign w_load     = w_fmt_valid && w_tx_ready;
   assign o_rd_addr  = r_rd_addr;
   assign o_tx       = r_tx;

   // One decimal position per cycle: pick the largest multiple of the place value that fits.
   always_comb begin
      case (r_pos)
         3'd0:    w_place = 17'd10000;
         3'd1:    w_place = 17'd1000;
         3'd2:    w_place = 17'd100;
         3'd3:    w_place = 17'd10;
         default: w_place = 17'd1;
      endcase
      w_digit = 4'd0;
      w_sub   = 17'd0;
      for (int j = 1; j <= 9; j++) begin
         if (r_mag >= 17'(j) * w_place) begin
            w_digit = 4'(j);
            w_sub   = 17'(j) * w_place;
         end
      end
      w_first = 3'd4;
      for (int k = 3; k >= 0; k--) begin
         if (r_dig[3'(k)] != 4'd0) w_first = 3'(k);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= c_ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_ST_IDLE:  if (i_start) w_state_next = c_ST_CHECK;
         c_ST_CHECK: w_state_next = w_dim_bad ? c_ST_IDLE : c_ST_ADDR;
         c_ST_ADDR:  w_state_next = c_ST_READ;
         c_ST_READ:  w_state_next = c_ST_WAIT;
         c_ST_WAIT:  w_state_next = c_ST_CONV;
         c_ST_CONV:  if (r_pos == 3'd4) w_state_next = r_neg ? c_ST_SIGN : c_ST_DIGIT;
         c_ST_SIGN:  if (w_load) w_state_next = c_ST_DIGIT;
         c_ST_DIGIT: if (w_load && (r_dpos == 3'd4)) w_state_next = c_ST_SEP;
         c_ST_SEP:   if (w_load) w_state_next = w_last_col ? c_ST_LF : c_ST_NEXT;
         c_ST_LF:    if (w_load) w_state_next = c_ST_NEXT;
         // Waiting for the line to go idle keeps the next element's first start bit close to its capture.
         c_ST_NEXT:  if (!r_tx_active) w_state_next = (w_last_col && w_last_row) ? c_ST_DONE : c_ST_ADDR;
         c_ST_DONE:  w_state_next = c_ST_IDLE;
         default:    w_state_next = c_ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_error     = 1'b0;
      w_fmt_valid = 1'b0;
      w_fmt_byte  = 8'h00;
      case (r_state)
         c_ST_IDLE:  ;
         c_ST_CHECK: o_error = w_dim_bad;
         c_ST_DONE:  o_done = 1'b1;
         c_ST_SIGN: begin
            o_busy      = 1'b1;
            w_fmt_valid = 1'b1;
            w_fmt_byte  = 8'h2D;
         end
         c_ST_DIGIT: begin
            o_busy      = 1'b1;
            w_fmt_valid = 1'b1;
            w_fmt_byte  = 8'h30 + {4'd0, r_dig[r_dpos]};
         end
         c_ST_SEP: begin
            o_busy      = 1'b1;
            w_fmt_valid = 1'b1;
            w_fmt_byte  = w_last_col ? 8'h0D : 8'h20;
         end
         c_ST_LF: begin
            o_busy      = 1'b1;
            w_fmt_valid = 1'b1;
            w_fmt_byte  = 8'h0A;
         end
         default: o_busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_base    <= 9'd0;
         r_rd_addr <= 9'd0;
         r_m       <= 32'd0;
         r_n       <= 32'd0;
         r_row     <= 3'd0;
         r_col     <= 3'd0;
         r_idx     <= 5'd0;
         r_neg     <= 1'b0;
         r_mag     <= 17'd0;
         r_dig     <= '0;
         r_pos     <= 3'd0;
         r_dpos    <= 3'd0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (i_start) begin
                  r_base <= i_base_addr;
                  r_m    <= i_m;
                  r_n    <= i_n;
               end
            end
            c_ST_CHECK: begin
               r_row <= 3'd0;
               r_col <= 3'd0;
               r_idx <= 5'd0;
            end
            // Row-major order makes r*n+c a simple running element index.
            c_ST_ADDR: r_rd_addr <= r_base + {4'd0, r_idx};
            c_ST_WAIT: begin
               r_neg <= i_rd_data[15];
               r_mag <= w_elem_mag;
               r_pos <= 3'd0;
            end
            c_ST_CONV: begin
               r_dig[r_pos] <= w_digit;
               r_mag        <= r_mag - w_sub;
               r_pos        <= r_pos + 3'd1;
               if (r_pos == 3'd4) r_dpos <= w_first;
            end
            c_ST_DIGIT: if (w_load) r_dpos <= r_dpos + 3'd1;
            c_ST_NEXT: begin
               if (!r_tx_active) begin
                  r_idx <= r_idx + 5'd1;
                  if (w_last_col) begin
                     r_col <= 3'd0;
                     r_row <= r_row + 3'd1;
                  end else begin
                     r_col <= r_col + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // A load in the last stop-bit cycle starts the next frame with no idle gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tx        <= 1'b1;
         r_tx_active <= 1'b0;
         r_tx_shift  <= 9'd0;
         r_bit_cnt   <= 4'd0;
         r_baud_cnt  <= '0;
      end else if (w_load) begin
         r_tx        <= 1'b0;
         r_tx_shift  <= {1'b1, w_fmt_byte};
         r_bit_cnt   <= 4'd0;
         r_baud_cnt  <= '0;
         r_tx_active <= 1'b1;
      end else if (r_tx_active) begin
         if (r_baud_cnt == c_BAUD_LAST) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 4'd9) begin
               r_tx_active <= 1'b0;
            end else begin
               r_tx       <= r_tx_shift[0];
               r_tx_shift <= {1'b0, r_tx_shift[8:1]};
               r_bit_cnt  <= r_bit_cnt + 4'd1;
            end
         end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_matrix_uart_printer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_matrix_uart_printer                                         |
// | Desc     : Directed vector bench for matrix_uart_printer (BAUD_DIV = 4).  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_matrix_uart_printer;

   localparam int c_BD    = 4;
   localparam int c_FRAME = 10 * c_BD;

   typedef struct packed {
      int               m;
      int               n;
      logic [8:0]       base;
      logic [5:0][15:0] data;
      int               len;
      logic [127:0]     exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [8:0]  i_base_addr = 9'd0;
   logic [31:0] i_m = 32'd0;
   logic [31:0] i_n = 32'd0;
   logic [31:0] i_rd_data;
   logic [8:0]  o_rd_addr;
   logic        o_tx, o_busy, o_done, o_error;

   logic [15:0] mem [512];
   vec_t        vecs [3];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [7:0]  rx_q [$];
   int          rx_t [$];
   logic [8:0]  addr_q [$];
   logic [8:0]  prev_addr = 9'd0;
   int          rx_bad = 0;
   int          done_cnt = 0, err_cycles = 0, busy_cnt = 0, txlow_cnt = 0;

   matrix_uart_printer #(.BAUD_DIV(c_BD), .MAX_DIM(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_m         (i_m),
      .i_n         (i_n),
      .o_rd_addr   (o_rd_addr),
      .i_rd_data   (i_rd_data),
      .o_tx        (o_tx),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_error     (o_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Storage with one-cycle latency; junk in the upper half must be ignored.
   always @(posedge clk) i_rd_data <= {16'hA5C3, mem[o_rd_addr]};

   initial begin
      forever begin
         @(negedge clk);
         if (o_done)  done_cnt++;
         if (o_error) err_cycles++;
         if (o_busy)  busy_cnt++;
         if (!o_tx)   txlow_cnt++;
         if (o_rd_addr !== prev_addr) begin
            if (o_busy) addr_q.push_back(o_rd_addr);
            prev_addr = o_rd_addr;
         end
      end
   end

   // UART receiver: every sample of a bit must agree, so bit width is checked exactly.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && o_tx === 1'b0) begin
            logic [9:0] bits;
            logic       ok;
            logic       abort;
            int         t0;
            t0 = cyc; ok = 1'b1; abort = 1'b0; bits = '0;
            for (int b = 0; b < 10 && !abort; b++) begin
               for (int s = 0; s < c_BD && !abort; s++) begin
                  if (b != 0 || s != 0) @(negedge clk);
                  if (!rst_n) abort = 1'b1;
                  else if (s == 0) bits[b] = o_tx;
                  else if (o_tx !== bits[b]) ok = 1'b0;
               end
            end
            if (!abort) begin
               if (!ok || bits[0] !== 1'b0 || bits[9] !== 1'b1) rx_bad++;
               rx_q.push_back(bits[8:1]);
               rx_t.push_back(t0);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int v, input int i);
      return vecs[v].exp[(vecs[v].len - 1 - i) * 8 +: 8];
   endfunction

   task automatic run_vec(input int v, input bit second_start);
      bit got;
      int t_start, t_done;
      logic busy_at_done;
      for (int k = 0; k < vecs[v].m * vecs[v].n; k++)
         mem[vecs[v].base + 9'(k)] = vecs[v].data[k];
      rx_q.delete(); rx_t.delete(); addr_q.delete();
      rx_bad = 0; done_cnt = 0;
      i_m = vecs[v].m; i_n = vecs[v].n; i_base_addr = vecs[v].base;
      i_start = 1'b1; t_start = cyc;
      @(negedge clk);
      i_start = 1'b0;
      // Scramble the configuration inputs after acceptance.
      i_m = 32'd9; i_n = 32'd0; i_base_addr = 9'h1FF;
      got = 1'b0; t_done = 0; busy_at_done = 1'b1;
      for (int k = 0; k < 5000 && !got; k++) begin
         @(negedge clk);
         if (k == 50) check("busy_mid", o_busy, 1);
         if (second_start) begin
            i_m = 32'd1; i_n = 32'd1;
            i_start = (k == 100);
         end
         if (o_done) begin
            got = 1'b1; t_done = cyc; busy_at_done = o_busy;
         end
      end
      i_start = 1'b0;
      check("done_seen", got, 1);
      check("busy_at_done", busy_at_done, 0);
      repeat (3) @(negedge clk);
      check("done_single", done_cnt, 1);
      if (v == 0) check("dur_ge_120", ((t_done - t_start) >= 120), 1);
      check("byte_count", rx_q.size(), vecs[v].len);
      check("frame_errors", rx_bad, 0);
      for (int i = 0; i < rx_q.size() && i < vecs[v].len; i++) begin
         check($sformatf("v%0d_byte%0d", v, i), rx_q[i], exp_byte(v, i));
         if (i > 0 && exp_byte(v, i - 1) != 8'h20 && exp_byte(v, i - 1) != 8'h0A)
            check($sformatf("v%0d_gap%0d", v, i), rx_t[i] - rx_t[i - 1], c_FRAME);
      end
      check("addr_count", addr_q.size(), vecs[v].m * vecs[v].n);
      for (int k = 0; k < addr_q.size() && k < vecs[v].m * vecs[v].n; k++)
         check($sformatf("v%0d_addr%0d", v, k), addr_q[k], vecs[v].base + 9'(k));
   endtask

   initial begin
      vecs[0].m = 1; vecs[0].n = 1; vecs[0].base = 9'd300; vecs[0].data = '0;
      vecs[0].data[0] = 16'd7;
      vecs[0].len = 3;  vecs[0].exp = 128'("7\015\012");
      vecs[1].m = 2; vecs[1].n = 2; vecs[1].base = 9'd10; vecs[1].data = '0;
      vecs[1].data[0] = 16'd1;  vecs[1].data[1] = 16'hFFFE;
      vecs[1].data[2] = 16'd30; vecs[1].data[3] = 16'd4;
      vecs[1].len = 12; vecs[1].exp = 128'("1 -2\015\01230 4\015\012");
      vecs[2].m = 1; vecs[2].n = 3; vecs[2].base = 9'd100; vecs[2].data = '0;
      vecs[2].data[0] = 16'd0; vecs[2].data[1] = 16'h8000; vecs[2].data[2] = 16'h7FFF;
      vecs[2].len = 16; vecs[2].exp = 128'("0 -32768 32767\015\012");
      for (int a = 0; a < 512; a++) mem[a] = 16'h0;

      repeat (3) @(negedge clk);
      check("reset_tx", o_tx, 1);
      check("reset_busy", o_busy, 0);
      check("reset_done", o_done, 0);
      check("reset_error", o_error, 0);
      check("reset_addr", o_rd_addr, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 3; v++) run_vec(v, 1'b0);

      // Illegal dimensions: single error pulse and nothing else.
      for (int e = 0; e < 2; e++) begin
         err_cycles = 0; busy_cnt = 0; txlow_cnt = 0; done_cnt = 0;
         i_m = (e == 0) ? 32'd0 : 32'd2;
         i_n = (e == 0) ? 32'd2 : 32'd6;
         i_base_addr = 9'd0;
         i_start = 1'b1;
         @(negedge clk);
         i_start = 1'b0;
         repeat (20) @(negedge clk);
         check($sformatf("err%0d_pulse", e), err_cycles, 1);
         check($sformatf("err%0d_busy", e), busy_cnt, 0);
         check($sformatf("err%0d_txlow", e), txlow_cnt, 0);
         check($sformatf("err%0d_done", e), done_cnt, 0);
      end

      // Second start during the 2x2 transfer must be ignored.
      run_vec(1, 1'b1);

      // Reset pulse while a zero data bit is on the line, then a clean rerun.
      begin
         bit seen;
         for (int k = 0; k < 4; k++) mem[vecs[1].base + 9'(k)] = vecs[1].data[k];
         i_m = 32'd2; i_n = 32'd2; i_base_addr = vecs[1].base;
         i_start = 1'b1;
         @(negedge clk);
         i_start = 1'b0;
         seen = 1'b0;
         for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (o_tx === 1'b0) seen = 1'b1;
         end
         check("rst_start_bit_seen", seen, 1);
         repeat (9) @(negedge clk);
         check("rst_pre_tx_low", o_tx, 0);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         check("rst_tx_high", o_tx, 1);
         check("rst_busy_low", o_busy, 0);
         busy_cnt = 0; txlow_cnt = 0; done_cnt = 0;
         repeat (60) @(negedge clk);
         check("rst_quiet_tx", txlow_cnt, 0);
         check("rst_quiet_busy", busy_cnt, 0);
         check("rst_quiet_done", done_cnt, 0);
         run_vec(1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/matrix_uart_printer.md
Name: matrix_uart_printer

Overview:
Transmit-side counterpart of the UART matrix input parser. On a start pulse it reads an m x n matrix row-major from Matrix_storage and converts each element to signed decimal ASCII. It streams the text out through an embedded 8N1 UART transmitter. It sits behind the Storage_Mux display port and drives the board uart_tx pin.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz.
BAUD, 115200, UART bit rate.
BAUD_DIV, CLK_FREQ/BAUD (217), clock cycles per UART bit; benches override it directly (e.g. 4).
MAX_DIM, 5, largest legal m or n.

Ports:
clk  input  1  system clock (divided clock).
rst_n  input  1  synchronous active-low reset.
i_start  input  1  one-cycle start pulse; ignored while o_busy=1.
i_base_addr  input  9  storage address of element (0,0).
i_m  input  32  row count; legal range 1..MAX_DIM.
i_n  input  32  column count; legal range 1..MAX_DIM.
o_rd_addr  output  9  storage read address.
i_rd_data  input  32  storage read data; low 16 bits are a signed element.
o_tx  output  1  UART serial out; idle high.
o_busy  output  1  high from the cycle after an accepted start until o_done.
o_done  output  1  one-cycle pulse after the last stop bit.
o_error  output  1  one-cycle pulse when dimensions are illegal.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). All state is sampled only on posedge clk.
- Reset values: o_tx=1, o_busy=0, o_done=0, o_error=0, o_rd_addr=0, FSM=IDLE.
- Reset asserted mid-operation: at the next edge o_tx=1 and the FSM returns to IDLE. A truncated frame is acceptable.
- i_start in IDLE latches base, m and n, then moves to CHECK.
- CHECK: if m or n is 0 or greater than MAX_DIM, pulse o_error for one cycle, send nothing, return to IDLE. o_busy stays 0 in this case.
- Otherwise set o_busy=1, r=0, c=0 and go to READ.
- READ: o_rd_addr = base + r*n + c, truncated to 9 bits. Storage has one-cycle read latency. The address is held and i_rd_data[15:0] is captured on the second rising edge after o_rd_addr updates.
- CONVERT:
  - Record the sign. Magnitude = two's-complement absolute value, 17-bit unsigned, so -32768 maps to 32768.
  - Produce 5 decimal digits by repeated subtraction of 10000, 1000, 100, 10, 1. Each subtraction or compare takes one cycle.
  - Leading zeros are suppressed; value 0 emits a single "0".
- Byte emission order per element:
  - "-" (0x2D) if negative, then the digits.
  - Then a space (0x20) if c < n-1, else CR (0x0D) followed by LF (0x0A).
  - There is no trailing space on any row.
- Advance: c++; when c reaches n, set c=0 and r++. When r reaches m after the last LF, go to DONE.
- DONE: o_done pulses one cycle, o_busy drops in the same cycle, FSM returns to IDLE.
- UART TX (8N1, LSB first):
  - Frame = start bit 0, 8 data bits, stop bit 1.
  - Each bit lasts exactly BAUD_DIV cycles, so one frame is 10*BAUD_DIV cycles.
  - The first start bit begins no later than 2*BAUD_DIV cycles after the element's data is captured.
  - Consecutive bytes within an element are back-to-back: the next start bit follows the stop bit with zero idle cycles.
  - Conversion of the next element may add idle-high gaps between frames; a gap must never corrupt a frame.
- The byte load uses a ready/valid handshake between the formatter and the TX shifter. The formatter holds the byte until the shifter accepts it. The shifter accepts only while idle or in the final cycle of a stop bit.
- i_start while busy: ignored, with no effect on the current output.
- i_m and i_n changes after acceptance: no effect; values are latched at start.

Test Plan:
- BAUD_DIV=4, 1x1, element 7 -> bytes 0x37,0x0D,0x0A. o_done arrives at least 120 cycles after start. Each bit lasts exactly 4 cycles.
- 2x2 at base 10, data {1,-2,30,4} -> "1 -2\r\n30 4\r\n" (12 bytes). o_rd_addr sequence 10,11,12,13.
- 1x3 with {0,-32768,32767} -> "0 -32768 32767\r\n". Checks zero and both 16-bit extremes.
- i_m=0 or i_n=6 -> o_error single pulse; o_tx stays high; o_busy stays 0; no o_done.
- A second i_start mid-transfer in the 2x2 case -> ignored; the output byte stream is identical to the single-start run.
- rst_n low for 1 cycle during a data bit -> o_tx=1 next edge, o_busy=0. A following start produces a correct full stream.
